turtle_cpu_mem_sequencer: RTL and testbench

Multi-cycle memory sequencer that lets the Turtle CPU core run against memories with variable latency instead of single-cycle arrays. Sits between the core's instruction/data memory ports and external memories with req/ack handshakes. Produces a one-cycle core_step strobe that advances architectural state only once an instruction's fetch and any data access have completed. Adds run/halt control, a bus timeout with sticky error, and a retired-instruction counter.

---
 rtl/turtle_mem_seq_pkg.sv | 23 ++
 rtl/turtle_mem_seq_bus_timeout_counter.sv | 41 ++++
 rtl/turtle_cpu_mem_sequencer.sv | 172 +++++++++++++++++
 tb/tb_turtle_cpu_mem_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turtle_mem_seq_pkg.sv
// Shared types and helpers for the Turtle CPU memory sequencer.
// Holds the sequencer state encoding and bus-timeout sizing functions.
package turtle_mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_DATA   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_ERROR  = 3'd5
  } seq_state_e;

  // A limit of zero means the bus may wait forever.
  function automatic logic timeout_enabled(input int unsigned cycles);
    return (cycles != 0);
  endfunction

  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/turtle_mem_seq_bus_timeout_counter.sv
// Wait-cycle counter shared by the fetch and data handshakes.
// Flags expiry when a request is still unanswered with the count at the limit.
module bus_timeout_counter
  import turtle_mem_seq_pkg::*;
#(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam logic             TO_EN     = timeout_enabled(LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at the limit so a disabled or stalled timer never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != LIMIT_VAL)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = TO_EN && count_en_i && (cnt_q == LIMIT_VAL);

endmodule

// File: rtl/turtle_cpu_mem_sequencer.sv
// Multi-cycle sequencer letting the Turtle core run against variable-latency
// memories; core_step is the core's clock enable, pulsed once per retired instruction.
module turtle_cpu_mem_sequencer
  import turtle_mem_seq_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned D_ADDR_W       = 12,
  parameter int unsigned INST_W         = 16,
  parameter int unsigned I_ADDR_W       = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RETIRE_CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [I_ADDR_W-1:0]     core_instruction_addr,
  output logic [INST_W-1:0]       core_instruction,
  input  logic [D_ADDR_W-1:0]     core_data_addr,
  input  logic [DATA_W-1:0]       core_write_data,
  input  logic                    core_dmem_write_enable,
  input  logic                    core_dmem_output_enable,
  output logic [DATA_W-1:0]       core_read_data,
  output logic                    core_step,
  output logic                    imem_req,
  output logic [I_ADDR_W-1:0]     imem_addr,
  input  logic                    imem_ack,
  input  logic [INST_W-1:0]       imem_rdata,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [D_ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]       dmem_wdata,
  input  logic                    dmem_ack,
  input  logic [DATA_W-1:0]       dmem_rdata,
  output logic                    halted,
  output logic                    bus_error,
  output logic [RETIRE_CNT_W-1:0] retired_count
);

  localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

  seq_state_e              state_q, state_d;
  logic [I_ADDR_W-1:0]     imem_addr_q, imem_addr_d;
  logic [INST_W-1:0]       inst_q, inst_d;
  logic [D_ADDR_W-1:0]     dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]       dmem_wdata_q, dmem_wdata_d;
  logic                    dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [RETIRE_CNT_W-1:0] retired_q, retired_d;

  logic step;
  logic mem_access;
  logic bus_req;
  logic bus_ack;
  logic timeout_expired;

  assign mem_access = core_dmem_write_enable || core_dmem_output_enable;
  assign bus_req    = (state_q == ST_FETCH) || (state_q == ST_DATA);
  assign bus_ack    = ((state_q == ST_FETCH) && imem_ack) || ((state_q == ST_DATA) && dmem_ack);

  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (!bus_req),
    .count_en_i (bus_req && !bus_ack),
    .expired_o  (timeout_expired)
  );

  // run is only honoured at commit points; every path into FETCH latches the PC.
  always_comb begin
    state_d      = state_q;
    imem_addr_d  = imem_addr_q;
    inst_d       = inst_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_we_d    = dmem_we_q;
    rdata_d      = rdata_q;
    step         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d     = ST_FETCH;
          imem_addr_d = core_instruction_addr;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = ST_EXEC;
        end else if (timeout_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_EXEC: begin
        if (mem_access) begin
          dmem_addr_d  = core_data_addr;
          dmem_wdata_d = core_write_data;
          dmem_we_d    = core_dmem_write_enable;
          state_d      = ST_DATA;
        end else begin
          step = 1'b1;
          if (run) begin
            state_d     = ST_FETCH;
            imem_addr_d = core_instruction_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (dmem_ack) begin
          if (!dmem_we_q) begin
            rdata_d = dmem_rdata;
          end
          state_d = ST_COMMIT;
        end else if (timeout_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_COMMIT: begin
        step = 1'b1;
        if (run) begin
          state_d     = ST_FETCH;
          imem_addr_d = core_instruction_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
    retired_d = step ? (retired_q + RETIRE_CNT_W'(1)) : retired_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      imem_addr_q  <= '0;
      inst_q       <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      rdata_q      <= '0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      imem_addr_q  <= imem_addr_d;
      inst_q       <= inst_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      rdata_q      <= rdata_d;
      retired_q    <= retired_d;
    end
  end

  assign core_instruction = inst_q;
  assign core_read_data   = rdata_q;
  assign core_step        = step;
  assign imem_req         = (state_q == ST_FETCH);
  assign imem_addr        = imem_addr_q;
  assign dmem_req         = (state_q == ST_DATA);
  assign dmem_we          = dmem_we_q;
  assign dmem_addr        = dmem_addr_q;
  assign dmem_wdata       = dmem_wdata_q;
  assign halted           = (state_q == ST_IDLE);
  assign bus_error        = (state_q == ST_ERROR);
  assign retired_count    = retired_q;

endmodule

// File: tb/tb_turtle_cpu_mem_sequencer.sv
// Self-checking bench for turtle_cpu_mem_sequencer: bench-side memories with
// programmable ack delay and a per-instruction latency/retire reference model.
module tb_turtle_cpu_mem_sequencer;

  localparam int TO = 4;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [11:0] core_instruction_addr;
  logic [15:0] core_instruction;
  logic [11:0] core_data_addr;
  logic [7:0]  core_write_data;
  logic        core_dmem_write_enable;
  logic        core_dmem_output_enable;
  logic [7:0]  core_read_data;
  logic        core_step;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [11:0] dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        dmem_ack;
  logic [7:0]  dmem_rdata;
  logic        halted;
  logic        bus_error;
  logic [15:0] retired_count;

  turtle_cpu_mem_sequencer #(
    .DATA_W(8), .D_ADDR_W(12), .INST_W(16), .I_ADDR_W(12),
    .TIMEOUT_CYCLES(TO), .RETIRE_CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .core_instruction_addr(core_instruction_addr), .core_instruction(core_instruction),
    .core_data_addr(core_data_addr), .core_write_data(core_write_data),
    .core_dmem_write_enable(core_dmem_write_enable),
    .core_dmem_output_enable(core_dmem_output_enable),
    .core_read_data(core_read_data), .core_step(core_step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .bus_error(bus_error), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          iDelay, dDelay, iWait, dWait, dReqCycles;
  logic [15:0] iData;
  logic [7:0]  dData;
  bit          dUnstable;
  logic [11:0] dAddrSeen;
  logic [7:0]  dWdataSeen;
  logic        dWeSeen;
  logic [15:0] retiredModel;
  logic [7:0]  readModel;

  // One clock: respond as the memories at the falling edge, then sample just after.
  task automatic step_cycle();
    @(negedge clk);
    if (imem_req) begin
      imem_ack   = (iWait >= iDelay);
      imem_rdata = iData;
      if (!imem_ack) iWait++;
    end else begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      iWait      = 0;
    end
    if (dmem_req) begin
      if (dReqCycles == 0) begin
        dAddrSeen  = dmem_addr;
        dWdataSeen = dmem_wdata;
        dWeSeen    = dmem_we;
      end else if (dmem_addr !== dAddrSeen || dmem_wdata !== dWdataSeen || dmem_we !== dWeSeen) begin
        dUnstable = 1'b1;
      end
      dReqCycles++;
      dmem_ack   = (dWait >= dDelay);
      dmem_rdata = dData;
      if (!dmem_ack) dWait++;
    end else begin
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = 8'($urandom);
      dWait      = 0;
    end
    #1;
  endtask

  // haltMode: 0 keep running, 1 drop run early in fetch, 2 drop run while in the data wait.
  task automatic exec_instr(input bit ld, input bit st, input bit both,
                            input logic [11:0] addr, input logic [7:0] wd, input logic [7:0] rd,
                            input logic [15:0] inst, input int iDel, input int dDel,
                            input logic [11:0] nextPc, input int haltMode,
                            output int cycles, output logic [11:0] fetchAddr,
                            output logic [15:0] retiredAtStart);
    bit done;
    iData = inst; dData = rd; iDelay = iDel; dDelay = dDel;
    iWait = 0; dWait = 0; dReqCycles = 0; dUnstable = 1'b0;
    cycles = 0; done = 1'b0; fetchAddr = 'x; retiredAtStart = 'x;
    while (!done && cycles < 200) begin
      step_cycle();
      cycles++;
      if (cycles == 1) begin
        fetchAddr               = imem_addr;
        retiredAtStart          = retired_count;
        core_dmem_write_enable  = st;
        core_dmem_output_enable = ld | (st & both);
        core_data_addr          = addr;
        core_write_data         = wd;
        if (haltMode == 1) run = 1'b0;
      end
      if (haltMode == 2 && dmem_req) run = 1'b0;
      if (core_step) done = 1'b1;
    end
    core_instruction_addr = nextPc;
  endtask

  task automatic start_from_idle(input logic [11:0] pc);
    step_cycle();
    total++;
    if (halted !== 1'b1) begin
      bad++; $display("[TB] FAIL idle_before_start halted=%0b want=1", halted);
    end
    core_instruction_addr = pc;
    run = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0;
    core_instruction_addr = '0; core_data_addr = '0; core_write_data = '0;
    core_dmem_write_enable = 1'b0; core_dmem_output_enable = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    iDelay = 0; dDelay = 0; iWait = 0; dWait = 0; iData = '0; dData = '0;
    dReqCycles = 0; dUnstable = 1'b0;
    retiredModel = '0; readModel = '0;
    #12;
    total++;
    if ({imem_req, dmem_req, core_step, bus_error, halted} !== 5'b00001) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b want=00001", {imem_req, dmem_req, core_step, bus_error, halted});
    end
    total++;
    if (core_instruction !== 16'h0 || core_read_data !== 8'h0 || retired_count !== 16'h0) begin
      bad++; $display("[TB] FAIL reset_data inst=%h rd=%h ret=%0d want all 0", core_instruction, core_read_data, retired_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_alu_sequence();
    int cyc; logic [11:0] fa; logic [15:0] rs;
    logic [15:0] insts [3];
    insts[0] = 16'h1111; insts[1] = 16'h2222; insts[2] = 16'h3333;
    start_from_idle(12'h000);
    for (int k = 0; k < 3; k++) begin
      exec_instr(0, 0, 0, '0, '0, '0, insts[k], 0, 0, 12'((k + 1) * 2), (k == 2) ? 1 : 0, cyc, fa, rs);
      total++;
      if (cyc !== 2) begin bad++; $display("[TB] FAIL alu_cycles k=%0d got=%0d want=2", k, cyc); end
      total++;
      if (fa !== 12'(k * 2)) begin bad++; $display("[TB] FAIL alu_imem_addr k=%0d got=%h want=%h", k, fa, 12'(k * 2)); end
      total++;
      if (core_instruction !== insts[k]) begin bad++; $display("[TB] FAIL alu_inst k=%0d got=%h want=%h", k, core_instruction, insts[k]); end
      total++;
      if (rs !== retiredModel) begin bad++; $display("[TB] FAIL alu_retired k=%0d got=%0d want=%0d", k, rs, retiredModel); end
      retiredModel++;
    end
    step_cycle();
    total++;
    if (retired_count !== 16'd3 || halted !== 1'b1) begin
      bad++; $display("[TB] FAIL alu_final ret=%0d halted=%0b want 3/1", retired_count, halted);
    end
  endtask

  task automatic test_load_wait();
    int cyc; logic [11:0] fa; logic [15:0] rs;
    start_from_idle(12'h010);
    exec_instr(1, 0, 0, 12'h0AB, 8'h00, 8'hA5, 16'h4A00, 0, 3, 12'h012, 1, cyc, fa, rs);
    readModel = 8'hA5; retiredModel++;
    total++;
    if (cyc !== 7) begin bad++; $display("[TB] FAIL load_cycles got=%0d want=7", cyc); end
    total++;
    if (dReqCycles !== 4 || dUnstable) begin bad++; $display("[TB] FAIL load_req_hold cycles=%0d unstable=%0b want 4/0", dReqCycles, dUnstable); end
    total++;
    if (core_read_data !== 8'hA5) begin bad++; $display("[TB] FAIL load_data got=%h want=a5", core_read_data); end
    total++;
    if (dAddrSeen !== 12'h0AB || dWeSeen !== 1'b0) begin bad++; $display("[TB] FAIL load_fields addr=%h we=%0b want 0ab/0", dAddrSeen, dWeSeen); end
  endtask

  task automatic test_store_both();
    int cyc; logic [11:0] fa; logic [15:0] rs;
    start_from_idle(12'h020);
    exec_instr(0, 1, 1, 12'h123, 8'h5C, 8'h77, 16'h5B00, 0, 1, 12'h022, 1, cyc, fa, rs);
    retiredModel++;
    total++;
    if (cyc !== 5) begin bad++; $display("[TB] FAIL store_cycles got=%0d want=5", cyc); end
    total++;
    if (dWeSeen !== 1'b1 || dAddrSeen !== 12'h123 || dWdataSeen !== 8'h5C) begin
      bad++; $display("[TB] FAIL store_fields we=%0b addr=%h wd=%h want 1/123/5c", dWeSeen, dAddrSeen, dWdataSeen);
    end
    total++;
    if (core_read_data !== readModel) begin bad++; $display("[TB] FAIL store_keeps_rdata got=%h want=%h", core_read_data, readModel); end
  endtask

  task automatic test_random();
    int cyc, kind, iDel, dDel, expCyc; logic [11:0] fa, pc, addr; logic [15:0] rs, inst;
    logic [7:0] wd, rd; bit ld, st, both;
    pc = 12'($urandom_range(0, 255) * 2);
    start_from_idle(pc);
    for (int k = 0; k < 20; k++) begin
      kind = $urandom_range(0, 2);
      ld = (kind == 1); st = (kind == 2); both = 1'($urandom_range(0, 1));
      addr = 12'($urandom); wd = 8'($urandom); rd = 8'($urandom); inst = 16'($urandom);
      iDel = $urandom_range(0, 3); dDel = $urandom_range(0, 3);
      expCyc = iDel + 2 + ((ld || st) ? dDel + 2 : 0);
      exec_instr(ld, st, both, addr, wd, rd, inst, iDel, dDel, pc + 12'd2, (k == 19) ? 1 : 0, cyc, fa, rs);
      total++;
      if (cyc !== expCyc) begin bad++; $display("[TB] FAIL rnd_cycles k=%0d got=%0d want=%0d", k, cyc, expCyc); end
      total++;
      if (fa !== pc || core_instruction !== inst) begin
        bad++; $display("[TB] FAIL rnd_fetch k=%0d addr=%h inst=%h want %h/%h", k, fa, core_instruction, pc, inst);
      end
      total++;
      if (rs !== retiredModel) begin bad++; $display("[TB] FAIL rnd_retired k=%0d got=%0d want=%0d", k, rs, retiredModel); end
      if (ld) readModel = rd;
      total++;
      if (core_read_data !== readModel) begin bad++; $display("[TB] FAIL rnd_rdata k=%0d got=%h want=%h", k, core_read_data, readModel); end
      if (ld || st) begin
        total++;
        if (dWeSeen !== st || dAddrSeen !== addr || dUnstable || dReqCycles !== dDel + 1 || (st && dWdataSeen !== wd)) begin
          bad++; $display("[TB] FAIL rnd_dmem k=%0d we=%0b addr=%h wd=%h n=%0d uns=%0b want %0b/%h/%h/%0d/0",
                          k, dWeSeen, dAddrSeen, dWdataSeen, dReqCycles, dUnstable, st, addr, wd, dDel + 1);
        end
      end
      retiredModel++;
      pc = pc + 12'd2;
    end
  endtask

  task automatic test_run_drop();
    int cyc; logic [11:0] fa; logic [15:0] rs; bit sawActivity;
    start_from_idle(12'h100);
    exec_instr(1, 0, 0, 12'h321, 8'h00, 8'h3C, 16'h6C00, 0, 2, 12'h102, 2, cyc, fa, rs);
    readModel = 8'h3C; retiredModel++;
    total++;
    if (cyc !== 6 || core_read_data !== 8'h3C) begin
      bad++; $display("[TB] FAIL rundrop_complete cycles=%0d rd=%h want 6/3c", cyc, core_read_data);
    end
    sawActivity = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step_cycle();
      if (!halted || imem_req || core_step) sawActivity = 1'b1;
    end
    total++;
    if (sawActivity) begin bad++; $display("[TB] FAIL rundrop_halt activity=1 want=0 halted=%0b", halted); end
    total++;
    if (retired_count !== retiredModel) begin bad++; $display("[TB] FAIL rundrop_retired got=%0d want=%0d", retired_count, retiredModel); end
  endtask

  task automatic test_timeout_ack_at_limit();
    int cyc; logic [11:0] fa; logic [15:0] rs;
    start_from_idle(12'h200);
    exec_instr(0, 0, 0, '0, '0, '0, 16'h7E57, TO, 0, 12'h202, 1, cyc, fa, rs);
    retiredModel++;
    total++;
    if (cyc !== TO + 2 || bus_error !== 1'b0 || core_instruction !== 16'h7E57) begin
      bad++; $display("[TB] FAIL ack_at_limit cycles=%0d err=%0b inst=%h want %0d/0/7e57", cyc, bus_error, core_instruction, TO + 2);
    end
  endtask

  task automatic test_reset_mid_fetch();
    start_from_idle(12'h300);
    iDelay = 1000; iWait = 0;
    step_cycle();
    step_cycle();
    total++;
    if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL midfetch_req_before got=%0b want=1", imem_req); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({imem_req, dmem_req, core_step, bus_error, halted} !== 5'b00001 || imem_addr !== 12'h0) begin
      bad++; $display("[TB] FAIL midfetch_ctrl got=%b addr=%h want=00001/000", {imem_req, dmem_req, core_step, bus_error, halted}, imem_addr);
    end
    total++;
    if (retired_count !== 16'h0 || core_instruction !== 16'h0 || core_read_data !== 8'h0) begin
      bad++; $display("[TB] FAIL midfetch_data ret=%0d inst=%h rd=%h want 0", retired_count, core_instruction, core_read_data);
    end
    run = 1'b0;
    retiredModel = '0; readModel = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_timeout();
    int reqCnt; bit errSeen, stepSeen, stayed;
    start_from_idle(12'h400);
    iDelay = 1000; iWait = 0;
    reqCnt = 0; errSeen = 1'b0; stepSeen = 1'b0;
    for (int n = 0; n < 30 && !errSeen; n++) begin
      step_cycle();
      if (bus_error) errSeen = 1'b1;
      else if (imem_req) reqCnt++;
      if (core_step) stepSeen = 1'b1;
    end
    total++;
    if (!errSeen || reqCnt !== TO + 1) begin
      bad++; $display("[TB] FAIL timeout_req_cycles err=%0b req=%0d want 1/%0d", errSeen, reqCnt, TO + 1);
    end
    total++;
    if (imem_req !== 1'b0 || halted !== 1'b0 || stepSeen || retired_count !== retiredModel) begin
      bad++; $display("[TB] FAIL timeout_outputs req=%0b halted=%0b step=%0b ret=%0d want 0/0/0/%0d",
                      imem_req, halted, stepSeen, retired_count, retiredModel);
    end
    stayed = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step_cycle();
      if (!bus_error || imem_req || dmem_req || core_step) stayed = 1'b0;
    end
    total++;
    if (!stayed) begin bad++; $display("[TB] FAIL timeout_sticky stayed=0 want=1 err=%0b", bus_error); end
  endtask

  initial begin
    test_reset();
    test_alu_sequence();
    test_load_wait();
    test_store_both();
    test_random();
    test_run_drop();
    test_timeout_ack_at_limit();
    test_reset_mid_fetch();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
